user_ram: RTL and testbench

- 16-entry user table for the server processing system.
- A host loads user records (7-bit ID + 8-bit payload). The block offers each valid, unserved record once to the server FSM as a 16-bit frame with a start pulse, then waits for the authentication verdict.
- Payloads of authenticated users are later overwritten by processed bytes arriving on the write-back port.

---
 rtl/user_sys_pkg.sv | 19 +
 rtl/user_ram_if.sv | 23 ++
 rtl/user_ram_pending_pick.sv | 20 ++
 rtl/user_ram.sv | 137 +++++++++++++
 tb/tb_user_ram.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/user_sys_pkg.sv
// Shared definitions for the user table, server FSM and operation unit.
// Frame layout: {valid, ID[6:0], data[7:0]}.
package user_sys_pkg;
    localparam int DEPTH     = 16;
    localparam int ADDR_W    = $clog2(DEPTH);
    localparam int ID_W      = 7;
    localparam int DATA_W    = 8;
    localparam int FRAME_W   = 1 + ID_W + DATA_W;

    localparam int VALID_BIT = 15;
    localparam int ID_MSB    = 14;
    localparam int ID_LSB    = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_AUTH = 2'd2
    } state_e;
endpackage

// File: rtl/user_ram_if.sv
// Host load, server verdict/frame and write-back signals of the user table.
interface user_ram_if;
    logic                               load;
    logic [user_sys_pkg::ADDR_W-1:0]    addr;
    logic [user_sys_pkg::DATA_W-1:0]    data_in;
    logic [user_sys_pkg::ID_W-1:0]      ID;
    logic                               auth_done;
    logic                               auth_fail;
    logic                               start;
    logic [user_sys_pkg::FRAME_W-1:0]   frame;
    logic [user_sys_pkg::DATA_W-1:0]    wb_data;
    logic                               wb_valid;

    modport master (
        output load, addr, data_in, ID, auth_done, auth_fail, wb_data, wb_valid,
        input  start, frame
    );

    modport slave (
        input  load, addr, data_in, ID, auth_done, auth_fail, wb_data, wb_valid,
        output start, frame
    );
endinterface

// File: rtl/user_ram_pending_pick.sv
// Lowest-set-bit priority encoder used to choose the write-back target.
module user_ram_pending_pick
    import user_sys_pkg::*;
(
    input  logic [DEPTH-1:0]  req,
    output logic [ADDR_W-1:0] idx,
    output logic              hit
);
    always_comb begin
        idx = '0;
        hit = 1'b0;
        // Scan downward so the lowest requesting index is written last.
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (req[k]) begin
                idx = ADDR_W'(k);
                hit = 1'b1;
            end
        end
    end
endmodule

// File: rtl/user_ram.sv
// User table: offers each valid, unserved record once to the server, tracks
// the verdict, and patches payloads of authenticated users on write-back.
module user_ram
    import user_sys_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    user_ram_if.slave bus
);
    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_SEND = SEND;
    localparam logic [1:0] ST_WAIT = WAIT_AUTH;

    logic [FRAME_W-1:0] mem_reg [DEPTH];
    logic [DEPTH-1:0]   served_reg;
    logic [DEPTH-1:0]   pending_reg;
    logic [DEPTH-1:0]   pending_verdict;
    logic [DEPTH-1:0]   load_sel;
    logic [DEPTH-1:0]   wb_sel;
    logic [DEPTH-1:0]   verdict_sel;

    logic [1:0]         state_reg;
    logic [ADDR_W-1:0]  ptr_reg;
    logic [ADDR_W-1:0]  cur_reg;
    logic               killed_reg;

    logic               in_wait;
    logic               verdict;
    logic               load_hits_cur;
    logic               accept;
    logic               auth_ok;
    logic               wb_hit;
    logic [ADDR_W-1:0]  wb_idx;
    logic [FRAME_W-1:0] load_rec;

    assign in_wait       = (state_reg == ST_WAIT);
    assign verdict       = in_wait && (bus.auth_done || bus.auth_fail);
    assign load_hits_cur = in_wait && bus.load && (bus.addr == cur_reg);
    // A reload of the in-flight entry voids its verdict, now or later.
    assign accept        = verdict && !killed_reg && !load_hits_cur;
    assign auth_ok       = bus.auth_done && !bus.auth_fail;

    always_comb begin
        load_rec                = '0;
        load_rec[VALID_BIT]     = 1'b1;
        load_rec[ID_MSB:ID_LSB] = bus.ID;
        load_rec[DATA_W-1:0]    = bus.data_in;
    end

    // Verdict lands first so a just-authenticated entry can take this write-back.
    always_comb begin
        pending_verdict = pending_reg;
        if (accept) begin
            pending_verdict[cur_reg] = auth_ok;
        end
    end

    user_ram_pending_pick u_pick (
        .req (pending_verdict),
        .idx (wb_idx),
        .hit (wb_hit)
    );

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_sel
            assign load_sel[gi]    = bus.load && (bus.addr == ADDR_W'(gi));
            assign wb_sel[gi]      = bus.wb_valid && wb_hit && (wb_idx == ADDR_W'(gi));
            assign verdict_sel[gi] = accept && (cur_reg == ADDR_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_reg[k] <= '0;
            end
            served_reg  <= '0;
            pending_reg <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (load_sel[k]) begin
                    mem_reg[k]     <= load_rec;
                    served_reg[k]  <= 1'b0;
                    pending_reg[k] <= 1'b0;
                end else begin
                    if (wb_sel[k]) begin
                        mem_reg[k][DATA_W-1:0] <= bus.wb_data;
                    end
                    if (verdict_sel[k]) begin
                        served_reg[k] <= 1'b1;
                    end
                    pending_reg[k] <= pending_verdict[k] && !wb_sel[k];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            ptr_reg    <= '0;
            cur_reg    <= '0;
            killed_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (mem_reg[ptr_reg][VALID_BIT] && !served_reg[ptr_reg]) begin
                        state_reg  <= ST_SEND;
                        cur_reg    <= ptr_reg;
                        killed_reg <= 1'b0;
                    end else begin
                        ptr_reg <= ptr_reg + 1'b1;
                    end
                end
                ST_SEND: begin
                    state_reg <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (load_hits_cur) begin
                        killed_reg <= 1'b1;
                    end
                    if (verdict) begin
                        state_reg <= ST_IDLE;
                        ptr_reg   <= cur_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.start = (state_reg == ST_SEND);
    assign bus.frame = (state_reg == ST_IDLE) ? '0 : mem_reg[cur_reg];
endmodule

// File: tb/tb_user_ram.sv
// Directed and randomized bench for user_ram against a table-level model.
module tb_user_ram;
    import user_sys_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    user_ram_if bus ();

    user_ram dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Model: table contents, flags, the open request and where the scan resumes.
    logic [15:0] m_mem [16];
    logic [15:0] m_served;
    logic [15:0] m_pending;
    bit          req_open;
    bit          req_killed;
    logic [3:0]  req_idx;
    logic [3:0]  scan_from;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.load      = 1'b0;
        bus.addr      = '0;
        bus.data_in   = '0;
        bus.ID        = '0;
        bus.auth_done = 1'b0;
        bus.auth_fail = 1'b0;
        bus.wb_valid  = 1'b0;
        bus.wb_data   = '0;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 16; k++) m_mem[k] = '0;
        m_served   = '0;
        m_pending  = '0;
        req_open   = 1'b0;
        req_killed = 1'b0;
        req_idx    = '0;
        scan_from  = '0;
    endtask

    // Apply the driven inputs at one rising edge and update the model by the table rules.
    task automatic tick();
        bit taken;
        @(posedge clk);
        if (req_open && (bus.auth_done || bus.auth_fail)) begin
            if (!req_killed && !(bus.load && bus.addr == req_idx)) begin
                m_served[req_idx]  = 1'b1;
                m_pending[req_idx] = bus.auth_done && !bus.auth_fail;
            end
            req_open  = 1'b0;
            scan_from = req_idx + 4'd1;
        end
        if (bus.wb_valid) begin
            taken = 1'b0;
            for (int k = 0; k < 16; k++) begin
                if (!taken && m_pending[k]) begin
                    m_mem[k][7:0] = bus.wb_data;
                    m_pending[k]  = 1'b0;
                    taken         = 1'b1;
                end
            end
        end
        if (bus.load) begin
            m_mem[bus.addr]     = {1'b1, bus.ID, bus.data_in};
            m_served[bus.addr]  = 1'b0;
            m_pending[bus.addr] = 1'b0;
            if (req_open && bus.addr == req_idx) req_killed = 1'b1;
        end
        @(negedge clk);
        clear_inputs();
    endtask

    function automatic bit find_next(input logic [3:0] from, output logic [3:0] idx);
        logic [3:0] k;
        idx = from;
        for (int i = 0; i < 16; i++) begin
            k = from + 4'(i);
            if (m_mem[k][15] && !m_served[k]) begin
                idx = k;
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic load_step(input logic [3:0] a, input logic [6:0] id, input logic [7:0] d);
        bus.load    = 1'b1;
        bus.addr    = a;
        bus.ID      = id;
        bus.data_in = d;
        tick();
    endtask

    task automatic wb_step(input logic [7:0] d);
        bus.wb_valid = 1'b1;
        bus.wb_data  = d;
        tick();
    endtask

    task automatic quiet(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            chk({tag, "_start"}, {15'b0, bus.start}, 16'h0000);
            chk({tag, "_frame"}, bus.frame, 16'h0000);
            tick();
        end
    endtask

    task automatic check_mem(input string tag);
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("%s[%0d]", tag, k), dut.mem_reg[k], m_mem[k]);
        end
    endtask

    // Wait (bounded) for the next start; it must carry the next eligible entry in scan order.
    task automatic begin_req(input string tag);
        logic [3:0] e;
        bit         found;
        int         waited;
        found  = find_next(scan_from, e);
        waited = 0;
        while (!bus.start && waited < 40) begin
            chk({tag, "_idle_frame"}, bus.frame, 16'h0000);
            tick();
            waited++;
        end
        chk({tag, "_start_seen"}, {15'b0, bus.start}, {15'b0, found});
        chk({tag, "_frame"}, bus.frame, m_mem[e]);
        tick();
        chk({tag, "_start_pulse"}, {15'b0, bus.start}, 16'h0000);
        chk({tag, "_frame_held"}, bus.frame, m_mem[e]);
        req_open   = 1'b1;
        req_killed = 1'b0;
        req_idx    = e;
    endtask

    task automatic rand_side();
        if ($urandom_range(0, 2) == 0) begin
            bus.load    = 1'b1;
            bus.addr    = ($urandom_range(0, 3) == 0) ? req_idx : 4'($urandom_range(0, 15));
            bus.ID      = 7'($urandom);
            bus.data_in = 8'($urandom);
        end
        if ($urandom_range(0, 2) == 0) begin
            bus.wb_valid = 1'b1;
            bus.wb_data  = 8'($urandom);
        end
    endtask

    task automatic hold(input int n, input bit rnd);
        for (int i = 0; i < n; i++) begin
            if (rnd) rand_side();
            tick();
            chk("wait_start", {15'b0, bus.start}, 16'h0000);
            chk("wait_frame", bus.frame, m_mem[req_idx]);
        end
    endtask

    // kind: 0 = done, 1 = fail, 2 = both, 3 = random choice
    task automatic verdict(input int kind, input bit rnd);
        int v;
        v = (kind == 3) ? int'($urandom_range(0, 2)) : kind;
        if (rnd) rand_side();
        bus.auth_done = (v != 1);
        bus.auth_fail = (v != 0);
        tick();
    endtask

    initial begin
        logic [3:0] nxt;
        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset
        quiet("reset_idle", 20);
        check_mem("reset_mem");

        // Three records served in address order, all authenticated
        do_reset();
        load_step(4'd2, 7'b1010001, 8'h11);
        load_step(4'd4, 7'b1110010, 8'h22);
        load_step(4'd9, 7'b1010100, 8'h33);
        chk("load_mem2", dut.mem_reg[2], 16'hD111);
        chk("load_mem4", dut.mem_reg[4], 16'hF222);
        chk("load_mem9", dut.mem_reg[9], 16'hD433);
        for (int i = 0; i < 3; i++) begin
            begin_req("plan");
            hold($urandom_range(0, 3), 1'b0);
            verdict(0, 1'b0);
        end
        wb_step(8'hAA);
        wb_step(8'hBB);
        wb_step(8'hCC);
        chk("wb_mem2", dut.mem_reg[2], 16'hD1AA);
        chk("wb_mem4", dut.mem_reg[4], 16'hF2BB);
        chk("wb_mem9", dut.mem_reg[9], 16'hD4CC);
        quiet("all_served", 40);

        // Entry 4 rejected: only 2 and 9 receive write-backs
        do_reset();
        load_step(4'd2, 7'b1010001, 8'h11);
        load_step(4'd4, 7'b1110010, 8'h22);
        load_step(4'd9, 7'b1010100, 8'h33);
        begin_req("fail2");  verdict(0, 1'b0);
        begin_req("fail4");  hold(2, 1'b0); verdict(1, 1'b0);
        begin_req("fail9");  verdict(0, 1'b0);
        wb_step(8'hAA);
        wb_step(8'hBB);
        wb_step(8'hCC);
        chk("fail_mem2", dut.mem_reg[2], 16'hD1AA);
        chk("fail_mem4", dut.mem_reg[4], 16'hF222);
        chk("fail_mem9", dut.mem_reg[9], 16'hD4BB);
        check_mem("fail_mem");

        // Reload of the in-flight entry voids its verdict and re-sends it
        do_reset();
        load_step(4'd2, 7'h15, 8'h40);
        begin_req("kill_first");
        hold(1, 1'b0);
        load_step(4'd2, 7'h2A, 8'h41);
        chk("kill_frame_new", bus.frame, 16'hAA41);
        verdict(0, 1'b0);
        begin_req("kill_resend");
        verdict(0, 1'b0);
        bus.load     = 1'b1;
        bus.addr     = 4'd2;
        bus.ID       = 7'h33;
        bus.data_in  = 8'h77;
        bus.wb_valid = 1'b1;
        bus.wb_data  = 8'h55;
        tick();
        chk("load_beats_wb", dut.mem_reg[2], 16'hB377);
        check_mem("kill_mem");

        // Minimum load-to-start latency, then randomized traffic
        do_reset();
        load_step(4'd1, 7'($urandom), 8'($urandom));
        chk("lat_c1_start", {15'b0, bus.start}, 16'h0000);
        chk("lat_c1_frame", bus.frame, 16'h0000);
        tick();
        chk("lat_c2_start", {15'b0, bus.start}, 16'h0001);
        for (int n = 0; n < 40; n++) begin
            if (!find_next(scan_from, nxt)) begin
                quiet("rnd_drained", 20);
                break;
            end
            begin_req("rnd");
            hold($urandom_range(0, 3), 1'b1);
            verdict(3, 1'b1);
        end
        repeat (17) wb_step(8'($urandom));
        check_mem("rnd_mem");

        // Asynchronous reset while a verdict is outstanding
        do_reset();
        load_step(4'd5, 7'h5A, 8'hC3);
        begin_req("arst");
        hold(1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_start", {15'b0, bus.start}, 16'h0000);
        chk("arst_frame", bus.frame, 16'h0000);
        model_reset();
        check_mem("arst_mem");
        @(negedge clk);
        rst_n = 1'b1;
        quiet("post_arst", 40);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
